// File: rtl/icache_rv32.sv
// Direct-mapped, read-only instruction cache for an RV32 fetch stage.
// Hits are answered combinationally in the same cycle as the address.
// Misses refill a whole line word-by-word over a request/acknowledge link.
module icache_rv32 #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iADDR,
    input  logic        iFLUSH,
    output logic [31:0] oDATA,
    output logic        oSTALL,
    output logic        oMEMREQ,
    output logic [31:0] oMEMADDR,
    input  logic        iMEMACK,
    input  logic [31:0] iMEMDATA
);

    localparam int unsigned WB = $clog2(WORDS);
    localparam int unsigned OB = WB + 2;
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TB = 32 - OB - IB;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_REFILL    = 2'd1;
    localparam logic [1:0] S_FILL_DONE = 2'd2;

    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS - 1);

    // Address fields of the current fetch
    logic [WB-1:0] word_sel;
    logic [IB-1:0] index;
    logic [TB-1:0] tag;

    // Line storage: tags and data carry no reset, validity is tracked separately
    logic [TB-1:0] tag_mem  [LINES];
    logic [31:0]   data_mem [LINES*WORDS];

    logic [LINES-1:0] valid_q, valid_d;
    logic [1:0]       state_q, state_d;
    logic [31-OB:0]   line_q, line_d;     // {tag, index} of the line being refilled
    logic [WB-1:0]    count_q, count_d;
    logic             flush_pending_q, flush_pending_d;

    logic hit;
    logic data_we;
    logic tag_we;

    // Byte offset within a word is the decoder's concern, not the cache's
    logic unused_addr_bits;
    assign unused_addr_bits = ^iADDR[1:0];

    // Split the fetch address into word select, index and tag
    always_comb begin
        word_sel = iADDR[OB-1:2];
        index    = iADDR[OB+IB-1:OB];
        tag      = iADDR[31:OB+IB];
    end

    // Zero-latency lookup; only IDLE may report a hit, and a flush forces a stall
    always_comb begin
        hit    = (state_q == S_IDLE) && valid_q[index] &&
                 (tag_mem[index] == tag) && !iFLUSH;
        oSTALL = !hit;
        oDATA  = hit ? data_mem[{index, word_sel}] : '0;
    end

    // Memory request is a pure decode of state so reset drops it immediately
    always_comb begin
        oMEMREQ  = (state_q == S_REFILL);
        oMEMADDR = oMEMREQ ? {line_q, count_q, 2'b00} : '0;
    end

    // Next-state, refill sequencing and valid-bit maintenance
    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        count_d         = count_q;
        valid_d         = valid_q;
        flush_pending_d = flush_pending_q;
        data_we         = 1'b0;
        tag_we          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iFLUSH) begin
                    valid_d = '0;
                end else if (!hit) begin
                    line_d         = iADDR[31:OB];
                    count_d        = '0;
                    valid_d[index] = 1'b0;
                    state_d        = S_REFILL;
                end
            end

            S_REFILL: begin
                if (iFLUSH) begin
                    flush_pending_d = 1'b1;
                end
                if (iMEMACK) begin
                    data_we = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_WORD) begin
                        tag_we  = 1'b1;
                        state_d = S_FILL_DONE;
                        // A flush seen anywhere in the refill, including this cycle, keeps the line invalid
                        if (!(flush_pending_q || iFLUSH)) begin
                            valid_d[line_q[IB-1:0]] = 1'b1;
                        end
                    end
                end
            end

            S_FILL_DONE: begin
                state_d         = S_IDLE;
                flush_pending_d = 1'b0;
                if (flush_pending_q || iFLUSH) begin
                    valid_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q         <= S_IDLE;
            valid_q         <= '0;
            line_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            line_q          <= line_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Refill writes into the tag and data arrays
    always_ff @(posedge iCLK) begin
        if (data_we) begin
            data_mem[{line_q[IB-1:0], count_q}] <= iMEMDATA;
        end
        if (tag_we) begin
            tag_mem[line_q[IB-1:0]] <= line_q[31-OB:IB];
        end
    end

endmodule

// File: tb/tb_icache_rv32.sv
// Self-checking bench for icache_rv32: directed scenarios followed by random
// fetch traffic, checked against a line-level model of cache contents.
module tb_icache_rv32;

    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned OB    = 4;
    localparam int unsigned IB    = 4;

    logic        iCLK;
    logic        iRST;
    logic [31:0] iADDR;
    logic        iFLUSH;
    logic [31:0] oDATA;
    logic        oSTALL;
    logic        oMEMREQ;
    logic [31:0] oMEMADDR;
    logic        iMEMACK;
    logic [31:0] iMEMDATA;

    icache_rv32 #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iADDR   (iADDR),
        .iFLUSH  (iFLUSH),
        .oDATA   (oDATA),
        .oSTALL  (oSTALL),
        .oMEMREQ (oMEMREQ),
        .oMEMADDR(oMEMADDR),
        .iMEMACK (iMEMACK),
        .iMEMDATA(iMEMDATA)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int vectors     = 0;
    int miscompares = 0;

    // Model: which line holds which tag
    bit          ref_valid [LINES];
    logic [23:0] ref_tag   [LINES];

    // Memory responder state
    int lat_plan[$];
    int cur_lat   = -1;
    int ack_wait  = 0;
    bit last_acked;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(LINES); i++) ref_valid[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Called on the falling edge: acknowledge the current request after its latency
    task automatic respond();
        last_acked = 1'b0;
        if (oMEMREQ) begin
            if (cur_lat < 0)
                cur_lat = (lat_plan.size() > 0) ? lat_plan.pop_front() : int'($urandom_range(0, 3));
            if (ack_wait >= cur_lat) begin
                iMEMACK    = 1'b1;
                iMEMDATA   = mem_word(oMEMADDR);
                last_acked = 1'b1;
                cur_lat    = -1;
                ack_wait   = 0;
            end else begin
                iMEMACK  = 1'b0;
                iMEMDATA = $urandom;
                ack_wait++;
            end
        end else begin
            // Stray acks while no request is outstanding must be ignored
            iMEMACK  = 1'($urandom_range(0, 1));
            iMEMDATA = $urandom;
            cur_lat  = -1;
            ack_wait = 0;
        end
    endtask

    // One clock: check outputs on the falling edge, then answer memory
    task automatic cycle(input string name, input bit stall, input logic [31:0] data,
                         input bit req, input logic [31:0] maddr);
        @(negedge iCLK);
        chk({name, ".stall"}, 32'(oSTALL), 32'(stall));
        chk({name, ".data"},  oDATA, data);
        chk({name, ".req"},   32'(oMEMREQ), 32'(req));
        if (req) chk({name, ".addr"}, oMEMADDR, maddr);
        respond();
        @(posedge iCLK);
        #1;
    endtask

    // Expected miss sequence; optional flush during a word, reset after some acks, or iADDR scrambling
    task automatic refill(input logic [31:0] a, input int flush_word, input int abort_acks, input bit scramble);
        logic [31:0] base;
        logic [IB-1:0] idx;
        int k;
        int guard;
        bit flushed;
        base    = {a[31:OB], 4'h0};
        idx     = a[OB+IB-1:OB];
        k       = 0;
        guard   = 0;
        flushed = 1'b0;
        iADDR   = a;
        cycle("miss_idle", 1'b1, 32'h0, 1'b0, 32'h0);
        ref_valid[idx] = 1'b0;
        while (k < int'(WORDS) && guard < 64) begin
            if (k == abort_acks) begin
                #2 iRST = 1'b0;
                #1;
                chk("rst_req",   32'(oMEMREQ), 32'h0);
                chk("rst_addr",  oMEMADDR, 32'h0);
                chk("rst_stall", 32'(oSTALL), 32'h1);
                chk("rst_data",  oDATA, 32'h0);
                lat_plan.delete();
                cur_lat  = -1;
                ack_wait = 0;
                iMEMACK  = 1'b0;
                @(posedge iCLK);
                #1 iRST = 1'b1;
                clear_model();
                return;
            end
            if (k == flush_word && !flushed) begin
                iFLUSH  = 1'b1;
                flushed = 1'b1;
            end
            if (scramble) iADDR = $urandom;
            cycle("refill", 1'b1, 32'h0, 1'b1, base + 32'(4 * k));
            iFLUSH = 1'b0;
            if (last_acked) k++;
            guard++;
        end
        chk("refill_words", 32'(k), 32'(WORDS));
        iADDR = a;
        cycle("fill_done", 1'b1, 32'h0, 1'b0, 32'h0);
        if (flushed) begin
            clear_model();
        end else begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[31:OB+IB];
        end
    endtask

    // Fetch an address until it hits, refilling as the model dictates
    task automatic fetch(input logic [31:0] a, input int flush_word, input int abort_acks, input bit scramble);
        logic [IB-1:0] idx;
        idx = a[OB+IB-1:OB];
        for (int t = 0; t < 3; t++) begin
            if (ref_valid[idx] && ref_tag[idx] == a[31:OB+IB]) begin
                iADDR = a;
                cycle("hit", 1'b0, mem_word({a[31:2], 2'b00}), 1'b0, 32'h0);
                return;
            end
            refill(a, (t == 0) ? flush_word : -1, (t == 0) ? abort_acks : -1, scramble);
        end
    endtask

    task automatic idle_flush(input logic [31:0] a);
        iADDR  = a;
        iFLUSH = 1'b1;
        cycle("flush_idle", 1'b1, 32'h0, 1'b0, 32'h0);
        iFLUSH = 1'b0;
        clear_model();
    endtask

    // Absolute runaway guard
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int r;
        iRST     = 1'b0;
        iADDR    = 32'h0;
        iFLUSH   = 1'b0;
        iMEMACK  = 1'b0;
        iMEMDATA = 32'h0;
        clear_model();

        #3;
        chk("reset.stall", 32'(oSTALL), 32'h1);
        chk("reset.data",  oDATA, 32'h0);
        chk("reset.req",   32'(oMEMREQ), 32'h0);
        chk("reset.addr",  oMEMADDR, 32'h0);
        @(posedge iCLK);
        @(posedge iCLK);
        #1 iRST = 1'b1;

        // Cold miss at 0 with one-cycle ack latency, then hit
        lat_plan = '{1, 1, 1, 1};
        fetch(32'h0, -1, -1, 1'b0);

        // Back-to-back hits in the same line
        fetch(32'h4, -1, -1, 1'b0);
        fetch(32'h8, -1, -1, 1'b0);
        fetch(32'hC, -1, -1, 1'b0);

        // Conflicting tags on index 0
        fetch(32'h100, -1, -1, 1'b0);
        fetch(32'h0,   -1, -1, 1'b0);

        // Flush during the second refill word
        fetch(32'h240, 1, -1, 1'b0);

        // Reset after two acks, then a full refill
        fetch(32'h388, -1, 2, 1'b0);

        // Long ack stall on word 0
        lat_plan = '{5};
        fetch(32'h4C4, -1, -1, 1'b0);

        // Random traffic over a small tag set to mix hits, conflicts and flushes
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) << 8) | ($urandom & 32'hFF);
            if (r == 1) a = a | 32'h8000_0000;
            if (r == 0)
                idle_flush(a);
            else if (r == 3)
                fetch(a, int'($urandom_range(0, 3)), -1, 1'b0);
            else if (r == 4)
                fetch(a, -1, int'($urandom_range(1, 3)), 1'b0);
            else
                fetch(a, -1, -1, r == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
